// File: rtl/cart_mem_pkg.sv
// Shared types and helpers for the cartridge memory responder.
// Holds the FSM state encoding, BSRAM window default and byte-lane select.
package cart_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROM_RD,
        RAM_RD,
        RAM_WR
    } state_t;

    localparam logic [24:0] BSRAM_BASE_DEF = 25'h1F00000;

    // Pick the addressed byte out of a 16-bit memory word.
    function automatic logic [7:0] lane_sel(
        input logic        a0,
        input logic [15:0] word
    );
        return a0 ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/cart_req_detect.sv
// Bus event detector: registers previous address and strobes and
// emits one-cycle pulses when a new read or write access appears.
module cart_req_detect
    import cart_mem_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          ce_n,
    input  logic          oe_n,
    input  logic          we_n,
    output logic          rd_new,
    output logic          wr_new
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic          ce_n_q;
    logic          ce_n_d;
    logic          oe_n_q;
    logic          oe_n_d;
    logic          we_n_q;
    logic          we_n_d;

    logic          rd_act;
    logic          rd_prev;
    logic          wr_act;
    logic          wr_prev;
    logic          addr_chg;

    // Compare the live bus with last cycle's snapshot.
    always_comb begin
        addr_d   = addr;
        ce_n_d   = ce_n;
        oe_n_d   = oe_n;
        we_n_d   = we_n;
        rd_act   = !ce_n && !oe_n;
        rd_prev  = !ce_n_q && !oe_n_q;
        wr_act   = !ce_n && !we_n;
        wr_prev  = !ce_n_q && !we_n_q;
        addr_chg = (addr != addr_q);
        rd_new   = rd_act && (!rd_prev || addr_chg);
        wr_new   = wr_act && (!wr_prev || addr_chg);
    end

    // Snapshot of the bus; strobes come out of reset inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
        end else begin
            addr_q <= addr_d;
            ce_n_q <= ce_n_d;
            oe_n_q <= oe_n_d;
            we_n_q <= we_n_d;
        end
    end

endmodule

// File: rtl/cart_mem_responder.sv
// Cartridge ROM/BSRAM responder on a shared 16-bit req/ack memory port.
// Keeps a one-word ROM hit register so repeated fetches need no access.
module cart_mem_responder
    import cart_mem_pkg::*;
#(
    parameter int                MEM_AW     = 25,
    parameter logic [MEM_AW-1:0] BSRAM_BASE = MEM_AW'(BSRAM_BASE_DEF),
    parameter int                ROM_AW     = 24,
    parameter int                BSRAM_AW   = 20
) (
    input  logic                MCLK,
    input  logic                RESET_N,
    input  logic [ROM_AW-1:0]   ROM_ADDR,
    input  logic                ROM_CE_N,
    input  logic                ROM_OE_N,
    input  logic                ROM_WORD,
    output logic [15:0]         ROM_Q,
    input  logic [BSRAM_AW-1:0] BSRAM_ADDR,
    input  logic [7:0]          BSRAM_D,
    input  logic                BSRAM_CE_N,
    input  logic                BSRAM_OE_N,
    input  logic                BSRAM_WE_N,
    output logic [7:0]          BSRAM_Q,
    output logic                mem_req,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [1:0]          mem_be,
    output logic [15:0]         mem_wdata,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_ack,
    output logic                busy
);

    state_t              state_q;
    state_t              state_d;
    logic                req_q;
    logic                req_d;
    logic                we_q;
    logic                we_d;
    logic [MEM_AW-1:0]   addr_q;
    logic [MEM_AW-1:0]   addr_d;
    logic [1:0]          be_q;
    logic [1:0]          be_d;
    logic [15:0]         wdata_q;
    logic [15:0]         wdata_d;
    logic [15:0]         rom_data_q;
    logic [15:0]         rom_data_d;
    logic [7:0]          ram_data_q;
    logic [7:0]          ram_data_d;
    logic [15:0]         hit_q;
    logic [15:0]         hit_d;
    logic [ROM_AW-2:0]   tag_q;
    logic [ROM_AW-2:0]   tag_d;
    logic                tag_vld_q;
    logic                tag_vld_d;
    logic [ROM_AW-2:0]   cap_tag_q;
    logic [ROM_AW-2:0]   cap_tag_d;
    logic                rom_lo_q;
    logic                rom_lo_d;
    logic                rom_word_q;
    logic                rom_word_d;
    logic                ram_lo_q;
    logic                ram_lo_d;
    logic                rom_pend_q;
    logic                rom_pend_d;
    logic                rd_pend_q;
    logic                rd_pend_d;
    logic                wr_pend_q;
    logic                wr_pend_d;

    logic                rom_rd_new;
    logic                rom_wr_new;
    logic                ram_rd_new;
    logic                ram_wr_new;
    logic                rom_on;
    logic                rom_match;
    logic                rom_hit;
    logic                rom_miss;
    logic                rom_set;
    logic                rom_clr;
    logic                rd_clr;
    logic                wr_clr;
    logic [MEM_AW-1:0]   rom_ext;
    logic [MEM_AW-1:0]   ram_ext;
    logic [7:0]          hit_byte;
    logic [7:0]          rom_rd_byte;
    logic [7:0]          ram_rd_byte;

    cart_req_detect #(
        .AW (ROM_AW)
    ) u_rom_det (
        .clk    (MCLK),
        .rst_n  (RESET_N),
        .addr   (ROM_ADDR),
        .ce_n   (ROM_CE_N),
        .oe_n   (ROM_OE_N),
        .we_n   (1'b1),
        .rd_new (rom_rd_new),
        .wr_new (rom_wr_new)
    );

    cart_req_detect #(
        .AW (BSRAM_AW)
    ) u_ram_det (
        .clk    (MCLK),
        .rst_n  (RESET_N),
        .addr   (BSRAM_ADDR),
        .ce_n   (BSRAM_CE_N),
        .oe_n   (BSRAM_OE_N),
        .we_n   (BSRAM_WE_N),
        .rd_new (ram_rd_new),
        .wr_new (ram_wr_new)
    );

    assign rom_on      = !ROM_CE_N && !ROM_OE_N;
    assign rom_match   = tag_vld_q && (ROM_ADDR[ROM_AW-1:1] == tag_q);
    assign rom_hit     = rom_on && rom_match;
    assign rom_miss    = rom_on && !rom_match;
    assign rom_ext     = MEM_AW'({ROM_ADDR[ROM_AW-1:1], 1'b0});
    assign ram_ext     = BSRAM_BASE + MEM_AW'(BSRAM_ADDR);
    assign hit_byte    = lane_sel(ROM_ADDR[0], hit_q);
    assign rom_rd_byte = lane_sel(rom_lo_q, mem_rdata);
    assign ram_rd_byte = lane_sel(ram_lo_q, mem_rdata);

    // While a ROM read is in flight the old tag still mismatches, so only a
    // fresh bus event may re-arm the ROM flag then.
    assign rom_set = rom_miss
                   && ((state_q != ROM_RD) || rom_rd_new || rom_wr_new);

    // Sticky pending flags; BSRAM events win over a same-cycle clear so
    // none is lost, the level-derived ROM flag lets the clear win.
    always_comb begin
        wr_pend_d  = (wr_pend_q && !wr_clr) || ram_wr_new;
        rd_pend_d  = (rd_pend_q && !rd_clr) || ram_rd_new;
        rom_pend_d = (rom_pend_q || rom_set) && !rom_clr;
    end

    // Arbitration, request launch and response capture.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rom_data_d = rom_data_q;
        ram_data_d = ram_data_q;
        hit_d      = hit_q;
        tag_d      = tag_q;
        tag_vld_d  = tag_vld_q;
        cap_tag_d  = cap_tag_q;
        rom_lo_d   = rom_lo_q;
        rom_word_d = rom_word_q;
        ram_lo_d   = ram_lo_q;
        rom_clr    = 1'b0;
        rd_clr     = 1'b0;
        wr_clr     = 1'b0;

        if (rom_hit) begin
            rom_data_d = ROM_WORD ? hit_q : {hit_byte, hit_byte};
        end

        unique case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    state_d = RAM_WR;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ram_ext;
                    be_d    = BSRAM_ADDR[0] ? 2'b10 : 2'b01;
                    wdata_d = {BSRAM_D, BSRAM_D};
                    wr_clr  = 1'b1;
                end else if (rom_pend_q) begin
                    state_d    = ROM_RD;
                    req_d      = 1'b1;
                    we_d       = 1'b0;
                    addr_d     = rom_ext;
                    be_d       = 2'b11;
                    cap_tag_d  = ROM_ADDR[ROM_AW-1:1];
                    rom_lo_d   = ROM_ADDR[0];
                    rom_word_d = ROM_WORD;
                    rom_clr    = 1'b1;
                end else if (rd_pend_q) begin
                    state_d  = RAM_RD;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = ram_ext;
                    be_d     = 2'b11;
                    ram_lo_d = BSRAM_ADDR[0];
                    rd_clr   = 1'b1;
                end
            end
            ROM_RD: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    hit_d      = mem_rdata;
                    tag_d      = cap_tag_q;
                    tag_vld_d  = 1'b1;
                    rom_data_d = rom_word_q ? mem_rdata
                                            : {rom_rd_byte, rom_rd_byte};
                end
            end
            RAM_RD: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    ram_data_d = ram_rd_byte;
                end
            end
            RAM_WR: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, request bundle, hit register and pending flags.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 2'b00;
            wdata_q    <= '0;
            rom_data_q <= '0;
            ram_data_q <= '0;
            hit_q      <= '0;
            tag_q      <= '0;
            tag_vld_q  <= 1'b0;
            cap_tag_q  <= '0;
            rom_lo_q   <= 1'b0;
            rom_word_q <= 1'b0;
            ram_lo_q   <= 1'b0;
            rom_pend_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rom_data_q <= rom_data_d;
            ram_data_q <= ram_data_d;
            hit_q      <= hit_d;
            tag_q      <= tag_d;
            tag_vld_q  <= tag_vld_d;
            cap_tag_q  <= cap_tag_d;
            rom_lo_q   <= rom_lo_d;
            rom_word_q <= rom_word_d;
            ram_lo_q   <= ram_lo_d;
            rom_pend_q <= rom_pend_d;
            rd_pend_q  <= rd_pend_d;
            wr_pend_q  <= wr_pend_d;
        end
    end

    assign ROM_Q     = rom_data_q;
    assign BSRAM_Q   = ram_data_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cart_mem_responder.sv
// Bench for cart_mem_responder: a memory model acks requests and
// checks each against a queue of expected transactions.
module tb_cart_mem_responder;

    localparam logic [24:0] BASE = 25'h1F00000;

    typedef struct packed {
        logic        we;
        logic [24:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } txn_t;

    logic        MCLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [23:0] ROM_ADDR = '0;
    logic        ROM_CE_N = 1'b1;
    logic        ROM_OE_N = 1'b1;
    logic        ROM_WORD = 1'b1;
    logic [15:0] ROM_Q;
    logic [19:0] BSRAM_ADDR = '0;
    logic [7:0]  BSRAM_D = '0;
    logic        BSRAM_CE_N = 1'b1;
    logic        BSRAM_OE_N = 1'b1;
    logic        BSRAM_WE_N = 1'b1;
    logic [7:0]  BSRAM_Q;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] rdata_m = '0;
    logic        ack_m = 1'b0;
    logic        stray_ack = 1'b0;
    logic        busy;

    txn_t        exp_q[$];
    logic [15:0] mem_model [logic [23:0]];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_cnt = 0;
    int          lat = 3;
    int          n0;

    cart_mem_responder dut (
        .MCLK       (MCLK),
        .RESET_N    (RESET_N),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_CE_N   (ROM_CE_N),
        .ROM_OE_N   (ROM_OE_N),
        .ROM_WORD   (ROM_WORD),
        .ROM_Q      (ROM_Q),
        .BSRAM_ADDR (BSRAM_ADDR),
        .BSRAM_D    (BSRAM_D),
        .BSRAM_CE_N (BSRAM_CE_N),
        .BSRAM_OE_N (BSRAM_OE_N),
        .BSRAM_WE_N (BSRAM_WE_N),
        .BSRAM_Q    (BSRAM_Q),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (rdata_m),
        .mem_ack    (ack_m | stray_ack),
        .busy       (busy)
    );

    initial forever #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic we, input logic [24:0] a,
                        input logic [1:0] be, input logic [15:0] wd);
        txn_t t;
        t.we    = we;
        t.addr  = a;
        t.be    = be;
        t.wdata = wd;
        exp_q.push_back(t);
    endtask

    task automatic wait_idle();
        int quiet;
        bit done;
        quiet = 0;
        done  = 1'b0;
        repeat (2) @(negedge MCLK);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge MCLK);
            if (!busy && !mem_req && !ack_m) quiet++;
            else quiet = 0;
            if (quiet >= 3) done = 1'b1;
        end
        chk("idle_wait", 32'(done), 32'd1);
    endtask

    task automatic wait_req();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge MCLK);
            if (mem_req) seen = 1'b1;
        end
        chk("req_wait", 32'(seen), 32'd1);
    endtask

    // Memory model: accept each new request, check it, ack after lat cycles.
    initial begin
        txn_t        t;
        txn_t        cur;
        logic [15:0] w;
        int          cnt;
        bit          in_txn;
        in_txn = 1'b0;
        cnt    = 0;
        cur    = '0;
        forever begin
            @(negedge MCLK);
            if (ack_m) begin
                ack_m  = 1'b0;
                in_txn = 1'b0;
            end
            if (!RESET_N) begin
                in_txn = 1'b0;
                ack_m  = 1'b0;
            end else if (in_txn) begin
                cnt++;
                if (cnt == lat) begin
                    w = mem_model.exists(cur.addr[24:1])
                        ? mem_model[cur.addr[24:1]] : 16'h0000;
                    if (cur.we) begin
                        if (cur.be[0]) w[7:0] = cur.wdata[7:0];
                        if (cur.be[1]) w[15:8] = cur.wdata[15:8];
                        mem_model[cur.addr[24:1]] = w;
                        rdata_m = 16'hDEAD;
                    end else begin
                        rdata_m = w;
                    end
                    ack_m = 1'b1;
                end
            end else if (mem_req) begin
                req_cnt++;
                in_txn = 1'b1;
                cnt    = 0;
                cur    = {mem_we, mem_addr, mem_be, mem_wdata};
                chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    chk("req_we", 32'(mem_we), 32'(t.we));
                    chk("req_addr", 32'(mem_addr), 32'(t.addr));
                    chk("req_be", 32'(mem_be), 32'(t.be));
                    if (t.we) chk("req_wdata", 32'(mem_wdata), 32'(t.wdata));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_model[24'h004000] = 16'hA55A;
        mem_model[24'hF80008] = 16'h1234;
        mem_model[24'h008001] = 16'hBEEF;
        mem_model[24'h010000] = 16'hC0DE;

        repeat (3) @(negedge MCLK);
        chk("rst_rom_q", 32'(ROM_Q), 32'h0);
        chk("rst_bsram_q", 32'(BSRAM_Q), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        RESET_N = 1'b1;
        repeat (2) @(negedge MCLK);

        push(1'b0, 25'h0008000, 2'b11, 16'h0);
        n0 = req_cnt;
        ROM_ADDR = 24'h008000;
        ROM_WORD = 1'b1;
        ROM_CE_N = 1'b0;
        ROM_OE_N = 1'b0;
        wait_idle();
        chk("rom_word", 32'(ROM_Q), 32'hA55A);
        chk("rom_req_cnt", 32'(req_cnt - n0), 32'd1);

        n0 = req_cnt;
        ROM_ADDR = 24'h008001;
        ROM_WORD = 1'b0;
        repeat (3) @(negedge MCLK);
        chk("hit_hi_byte", 32'(ROM_Q), 32'hA5A5);
        ROM_ADDR = 24'h008000;
        repeat (3) @(negedge MCLK);
        chk("hit_lo_byte", 32'(ROM_Q), 32'h5A5A);
        chk("hit_no_req", 32'(req_cnt - n0), 32'd0);
        ROM_CE_N = 1'b1;
        ROM_OE_N = 1'b1;

        push(1'b1, BASE + 25'h5, 2'b10, 16'h3C3C);
        BSRAM_ADDR = 20'h00005;
        BSRAM_D    = 8'h3C;
        BSRAM_CE_N = 1'b0;
        BSRAM_WE_N = 1'b0;
        wait_idle();
        chk("rom_coherent", 32'(ROM_Q), 32'h5A5A);
        BSRAM_WE_N = 1'b1;
        BSRAM_CE_N = 1'b1;
        @(negedge MCLK);

        push(1'b0, BASE + 25'h5, 2'b11, 16'h0);
        BSRAM_CE_N = 1'b0;
        BSRAM_OE_N = 1'b0;
        wait_idle();
        chk("ram_rd_odd", 32'(BSRAM_Q), 32'h3C);
        push(1'b0, BASE + 25'h10, 2'b11, 16'h0);
        BSRAM_ADDR = 20'h00010;
        wait_idle();
        chk("ram_rd_even", 32'(BSRAM_Q), 32'h34);
        push(1'b0, BASE + 25'h11, 2'b11, 16'h0);
        BSRAM_ADDR = 20'h00011;
        wait_idle();
        chk("ram_rd_chg", 32'(BSRAM_Q), 32'h12);
        BSRAM_CE_N = 1'b1;
        BSRAM_OE_N = 1'b1;
        @(negedge MCLK);

        push(1'b1, BASE + 25'h20, 2'b01, 16'h5A5A);
        push(1'b0, 25'h0010002, 2'b11, 16'h0);
        n0 = req_cnt;
        ROM_ADDR   = 24'h010002;
        ROM_WORD   = 1'b1;
        ROM_CE_N   = 1'b0;
        ROM_OE_N   = 1'b0;
        BSRAM_ADDR = 20'h00020;
        BSRAM_D    = 8'h5A;
        BSRAM_CE_N = 1'b0;
        BSRAM_WE_N = 1'b0;
        wait_idle();
        chk("simul_rom_q", 32'(ROM_Q), 32'hBEEF);
        chk("simul_cnt", 32'(req_cnt - n0), 32'd2);
        ROM_CE_N   = 1'b1;
        ROM_OE_N   = 1'b1;
        BSRAM_WE_N = 1'b1;
        BSRAM_CE_N = 1'b1;
        @(negedge MCLK);

        push(1'b1, BASE + 25'h30, 2'b01, 16'h7777);
        n0 = req_cnt;
        BSRAM_ADDR = 20'h00030;
        BSRAM_D    = 8'h77;
        BSRAM_CE_N = 1'b0;
        BSRAM_WE_N = 1'b0;
        repeat (20) @(negedge MCLK);
        BSRAM_WE_N = 1'b1;
        BSRAM_CE_N = 1'b1;
        wait_idle();
        chk("held_we_cnt", 32'(req_cnt - n0), 32'd1);

        push(1'b1, 25'h1FFFFFF, 2'b10, 16'hEEEE);
        BSRAM_ADDR = 20'hFFFFF;
        BSRAM_D    = 8'hEE;
        BSRAM_CE_N = 1'b0;
        BSRAM_WE_N = 1'b0;
        wait_idle();
        BSRAM_WE_N = 1'b1;
        BSRAM_CE_N = 1'b1;
        @(negedge MCLK);

        lat = 6;
        push(1'b0, 25'h0020000, 2'b11, 16'h0);
        ROM_ADDR = 24'h020000;
        ROM_CE_N = 1'b0;
        ROM_OE_N = 1'b0;
        wait_req();
        @(negedge MCLK);
        ROM_CE_N = 1'b1;
        ROM_OE_N = 1'b1;
        wait_idle();
        chk("strobe_drop", 32'(ROM_Q), 32'hC0DE);

        lat = 10;
        push(1'b0, 25'h0030000, 2'b11, 16'h0);
        ROM_ADDR = 24'h030000;
        ROM_CE_N = 1'b0;
        ROM_OE_N = 1'b0;
        wait_req();
        @(negedge MCLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req), 32'h0);
        chk("rst_mid_rom_q", 32'(ROM_Q), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        ROM_CE_N = 1'b1;
        ROM_OE_N = 1'b1;
        @(negedge MCLK);
        RESET_N = 1'b1;
        n0 = req_cnt;
        @(negedge MCLK);
        stray_ack = 1'b1;
        @(negedge MCLK);
        stray_ack = 1'b0;
        repeat (2) @(negedge MCLK);
        chk("stray_rom_q", 32'(ROM_Q), 32'h0);
        chk("stray_busy", 32'(busy), 32'h0);
        chk("stray_bsram_q", 32'(BSRAM_Q), 32'h0);

        lat = 3;
        push(1'b0, 25'h0020000, 2'b11, 16'h0);
        ROM_ADDR = 24'h020000;
        ROM_CE_N = 1'b0;
        ROM_OE_N = 1'b0;
        wait_idle();
        chk("post_rst_miss", 32'(req_cnt - n0), 32'd1);
        chk("post_rst_rom_q", 32'(ROM_Q), 32'hC0DE);
        ROM_CE_N = 1'b1;
        ROM_OE_N = 1'b1;
        repeat (3) @(negedge MCLK);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
